// File: rtl/tr_move_seq.sv
// AUTO-mode move sequencer for the TR stepper channel: runs one latched move command
// through a linear accel/cruise/decel period profile, counting steps on pulse_tick.
module tr_move_seq #(
    parameter int WIDTH_TR  = 16,
    parameter int WIDTH_CNT = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 dir_cmd,
    input  logic [WIDTH_CNT-1:0] steps_cmd,
    input  logic [WIDTH_TR-1:0]  period_start,
    input  logic [WIDTH_TR-1:0]  period_min,
    input  logic [WIDTH_TR-1:0]  period_delta,
    input  logic                 pulse_tick,
    output logic                 enable_AUTO,
    output logic                 dir_AUTO,
    output logic [WIDTH_TR-1:0]  period_AUTO,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [WIDTH_CNT-1:0] steps_left
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEL  = 3'd1;
    localparam logic [2:0] S_CRUISE = 3'd2;
    localparam logic [2:0] S_DECEL  = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state_q,   state_d;
    logic                 dir_q,     dir_d;
    logic [WIDTH_TR-1:0]  period_q,  period_d;
    logic [WIDTH_TR-1:0]  pstart_q,  pstart_d;
    logic [WIDTH_TR-1:0]  pmin_q,    pmin_d;
    logic [WIDTH_TR-1:0]  pdelta_q,  pdelta_d;
    logic [WIDTH_CNT-1:0] steps_q,   steps_d;
    logic [WIDTH_CNT-1:0] ramp_q,    ramp_d;
    logic                 aborted_q, aborted_d;

    logic [WIDTH_TR:0]    dec_w, inc_w;
    logic [WIDTH_TR-1:0]  dec_sat, inc_sat;
    logic [WIDTH_CNT-1:0] s_next;

    // One extra bit on both ramp sums so borrow/carry can be clamped instead of wrapping.
    always_comb begin
        dec_w   = {1'b0, period_q} - {1'b0, pdelta_q};
        inc_w   = {1'b0, period_q} + {1'b0, pdelta_q};
        dec_sat = (dec_w[WIDTH_TR] || (dec_w[WIDTH_TR-1:0] < pmin_q)) ? pmin_q : dec_w[WIDTH_TR-1:0];
        inc_sat = (inc_w > {1'b0, pstart_q}) ? pstart_q : inc_w[WIDTH_TR-1:0];
        s_next  = steps_q - WIDTH_CNT'(1);
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        period_d  = period_q;
        pstart_d  = pstart_q;
        pmin_d    = pmin_q;
        pdelta_d  = pdelta_q;
        steps_d   = steps_q;
        ramp_d    = ramp_q;
        aborted_d = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    dir_d     = dir_cmd;
                    pstart_d  = period_start;
                    pmin_d    = period_min;
                    pdelta_d  = period_delta;
                    steps_d   = steps_cmd;
                    period_d  = period_start;
                    ramp_d    = '0;
                    aborted_d = 1'b0;
                    if (steps_cmd == '0)
                        state_d = S_STOP;
                    else if (period_delta == '0 || period_start <= period_min)
                        state_d = S_CRUISE;
                    else
                        state_d = S_ACCEL;
                end
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                if (abort) begin
                    state_d   = S_STOP;
                    aborted_d = 1'b1;
                end else if (pulse_tick) begin
                    steps_d = s_next;
                    if (s_next == '0) begin
                        state_d = S_STOP;
                    end else begin
                        case (state_q)
                            S_ACCEL: begin
                                // Start braking once remaining steps fit inside the ramp already climbed.
                                if (s_next <= ramp_q) begin
                                    state_d  = S_DECEL;
                                    period_d = inc_sat;
                                end else begin
                                    period_d = dec_sat;
                                    ramp_d   = ramp_q + WIDTH_CNT'(1);
                                    if (dec_sat == pmin_q)
                                        state_d = S_CRUISE;
                                end
                            end
                            S_CRUISE: begin
                                if (s_next == ramp_q) begin
                                    state_d  = S_DECEL;
                                    period_d = inc_sat;
                                end
                            end
                            default: period_d = inc_sat;
                        endcase
                    end
                end
            end
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            period_q  <= '0;
            pstart_q  <= '0;
            pmin_q    <= '0;
            pdelta_q  <= '0;
            steps_q   <= '0;
            ramp_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            period_q  <= period_d;
            pstart_q  <= pstart_d;
            pmin_q    <= pmin_d;
            pdelta_q  <= pdelta_d;
            steps_q   <= steps_d;
            ramp_q    <= ramp_d;
            aborted_q <= aborted_d;
        end
    end

    assign enable_AUTO = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_STOP);
    assign dir_AUTO    = dir_q;
    assign period_AUTO = period_q;
    assign aborted     = aborted_q;
    assign steps_left  = steps_q;

endmodule

// File: tb/tb_tr_move_seq.sv
// Directed bench for tr_move_seq: table of full move profiles plus hand-written
// sequences for zero-step, abort, abort-vs-start and mid-move reset.
module tb_tr_move_seq;

    logic        clk = 1'b0;
    logic        rst, start, abort, dir_cmd, pulse_tick;
    logic [23:0] steps_cmd;
    logic [15:0] period_start, period_min, period_delta;
    logic        enable_AUTO, dir_AUTO, busy, done, aborted;
    logic [15:0] period_AUTO;
    logic [23:0] steps_left;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int steps;
        int ps;
        int pm;
        int pd;
        bit dir;
        int per[10];
    } vec_t;

    vec_t vecs[6];

    tr_move_seq #(.WIDTH_TR(16), .WIDTH_CNT(24)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dir_cmd(dir_cmd),
        .steps_cmd(steps_cmd), .period_start(period_start), .period_min(period_min),
        .period_delta(period_delta), .pulse_tick(pulse_tick),
        .enable_AUTO(enable_AUTO), .dir_AUTO(dir_AUTO), .period_AUTO(period_AUTO),
        .busy(busy), .done(done), .aborted(aborted), .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " enable"},  enable_AUTO, 0);
        check({tag, " dir"},     dir_AUTO,    0);
        check({tag, " period"},  period_AUTO, 0);
        check({tag, " busy"},    busy,        0);
        check({tag, " done"},    done,        0);
        check({tag, " aborted"}, aborted,     0);
        check({tag, " steps"},   steps_left,  0);
    endtask

    task automatic load_cmd(input int steps, input int ps, input int pm, input int pd, input bit d);
        steps_cmd    = 24'(steps);
        period_start = 16'(ps);
        period_min   = 16'(pm);
        period_delta = 16'(pd);
        dir_cmd      = d;
    endtask

    // Runs one complete move; mid-move a junk start with altered commands must be ignored.
    task automatic run_move(input vec_t v, input int id);
        string t;
        t = $sformatf("v%0d", id);
        load_cmd(v.steps, v.ps, v.pm, v.pd, v.dir);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check({t, " enable"}, enable_AUTO, 1);
        check({t, " busy"}, busy, 1);
        check({t, " dir"}, dir_AUTO, v.dir);
        check({t, " steps_left"}, steps_left, v.steps);
        for (int k = 0; k < v.steps; k++) begin
            check($sformatf("%s period step%0d", t, k + 1), period_AUTO, v.per[k]);
            pulse_tick = 1'b1;
            step_clk();
            pulse_tick = 1'b0;
            if (k < v.steps - 1) begin
                check($sformatf("%s steps_left tick%0d", t, k + 1), steps_left, v.steps - k - 1);
                check({t, " done early"}, done, 0);
                if (k == 0) begin
                    load_cmd(99, 7, 1, 50, ~v.dir);
                    start = 1'b1;
                end
                step_clk();
                start = 1'b0;
            end else begin
                check({t, " done"}, done, 1);
                check({t, " stop enable"}, enable_AUTO, 0);
                check({t, " stop busy"}, busy, 1);
                check({t, " stop period"}, period_AUTO, v.per[k]);
                check({t, " stop dir"}, dir_AUTO, v.dir);
                step_clk();
                check({t, " idle done"}, done, 0);
                check({t, " idle busy"}, busy, 0);
                check({t, " idle aborted"}, aborted, 0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{10, 1000, 600, 100, 1'b0, '{1000, 900, 800, 700, 600, 600, 700, 800, 900, 1000}};
        vecs[1] = '{5, 1000, 600, 100, 1'b1, '{1000, 900, 800, 900, 1000, 0, 0, 0, 0, 0}};
        vecs[2] = '{3, 500, 600, 100, 1'b1, '{500, 500, 500, 0, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{10, 1000, 650, 100, 1'b0, '{1000, 900, 800, 700, 650, 650, 750, 850, 950, 1000}};
        vecs[4] = '{4, 300, 100, 500, 1'b1, '{300, 100, 100, 300, 0, 0, 0, 0, 0, 0}};
        vecs[5] = '{3, 65000, 10000, 60000, 1'b0, '{65000, 10000, 65000, 0, 0, 0, 0, 0, 0, 0}};

        rst = 1'b1; start = 1'b0; abort = 1'b0; pulse_tick = 1'b0;
        load_cmd(0, 0, 0, 0, 1'b0);
        step_clk();
        step_clk();
        check_all_zero("reset");
        rst = 1'b0;
        step_clk();

        for (int i = 0; i < 6; i++) run_move(vecs[i], i);

        // Zero-step move: straight to STOP, enable never raised.
        load_cmd(0, 1234, 600, 100, 1'b1);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("zero done", done, 1);
        check("zero enable", enable_AUTO, 0);
        check("zero busy", busy, 1);
        check("zero period", period_AUTO, 1234);
        step_clk();
        check("zero idle done", done, 0);
        check("zero idle enable", enable_AUTO, 0);
        check("zero idle busy", busy, 0);

        // Abort coinciding with tick 3 of the 10-step profile.
        load_cmd(10, 1000, 600, 100, 1'b0);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pulse_tick = 1'b1;
            step_clk();
            pulse_tick = 1'b0;
            step_clk();
        end
        pulse_tick = 1'b1;
        abort = 1'b1;
        step_clk();
        pulse_tick = 1'b0;
        abort = 1'b0;
        check("abort done", done, 1);
        check("abort flag", aborted, 1);
        check("abort steps_left", steps_left, 8);
        check("abort enable", enable_AUTO, 0);
        check("abort period", period_AUTO, 800);
        step_clk();
        check("abort idle done", done, 0);
        check("abort idle busy", busy, 0);
        check("abort held", aborted, 1);

        // Abort beats start in IDLE.
        load_cmd(5, 1000, 600, 100, 1'b1);
        start = 1'b1;
        abort = 1'b1;
        step_clk();
        start = 1'b0;
        abort = 1'b0;
        check("idle abort busy", busy, 0);
        check("idle abort done", done, 0);
        check("idle abort steps", steps_left, 8);

        // Next start clears the aborted flag.
        load_cmd(0, 700, 600, 100, 1'b0);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("restart aborted cleared", aborted, 0);
        step_clk();

        // Reset during CRUISE, then a full move.
        load_cmd(3, 500, 600, 100, 1'b1);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        pulse_tick = 1'b1;
        step_clk();
        pulse_tick = 1'b0;
        check("pre-rst steps_left", steps_left, 2);
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        check_all_zero("midrst");
        step_clk();
        check("midrst no done", done, 0);
        run_move(vecs[0], 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
